uart_fifo: RTL and testbench

Parametrised successor to the single-byte UART peripheral. It adds a configurable data width, parity and stop bits, 16x oversampled receive with start-bit validation, and separate RX and TX FIFOs. It reports a parity error and a framing error per byte, plus a sticky overrun flag. It sits on the peripheral bus beside the timer and LED/switch blocks, and the CPU polls it through the same RXD/TXD/EFF/READ/STATUS/EN handshake.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_fifo.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART: parity modes, FSM encodings, baud divisor.
// Latency: n/a (constants, types and a constant function only).
// Backpressure: n/a.
`timescale 1ns/1ps
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // 16x oversampling tick divisor, truncated, never below 1
  function automatic int calc_div(input int clk_hz, input int baud);
    int d = clk_hz / (baud * 16);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous first-word fall-through FIFO with full/empty/occupancy outputs.
// Latency: a push is visible at the head the cycle after the push edge; pop_dat is combinational.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
`timescale 1ns/1ps
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  // Empty head reads as zero so the output is clean out of reset
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with 16x oversampled RX, configurable width/parity/stop bits, and RX/TX FIFOs.
// Latency: RX byte reaches the FIFO head ~3 cycles after the stop-bit midpoint; TX starts on the tick after the push.
// Backpressure: TX_STATUS=0 drops pushes silently; a full RX FIFO drops the byte and sets sticky RX_OVR.
`timescale 1ns/1ps
module uart_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic                        UART_TX,
  output logic [DATA_W-1:0]           UART_RXD,
  output logic                        RX_PERR,
  output logic                        RX_FERR,
  output logic                        RX_EFF,
  input  logic                        RX_READ,
  output logic                        RX_OVR,
  output logic [$clog2(RX_DEPTH):0]   RX_COUNT,
  input  logic [DATA_W-1:0]           UART_TXD,
  input  logic                        TX_EN,
  output logic                        TX_STATUS,
  output logic                        TX_BUSY
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit             HAS_PAR   = (PARITY != PAR_NONE);
  localparam bit             ODD_PAR   = (PARITY == PAR_ODD);

  // ---------------- tick generator ----------------
  logic [TCW-1:0] tick_cnt;
  logic           tick;

  assign tick = (tick_cnt == TCW'(DIV - 1));

  // Free-running 16x bit-rate tick shared by RX and TX
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- RX path ----------------
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  assign rx_fall = rx_prev && !rx_sync;

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t         rx_state;
  logic [3:0]        rx_tcnt;
  logic [BCW-1:0]    rx_bcnt;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_perr;
  logic              rx_push;
  logic [DATA_W+1:0] rx_push_dat;

  // Receive FSM: validate start at half bit, then sample each bit at its midpoint
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_IDLE;
      rx_tcnt     <= '0;
      rx_bcnt     <= '0;
      rx_shift    <= '0;
      rx_perr     <= 1'b0;
      rx_push     <= 1'b0;
      rx_push_dat <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_tcnt  <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt == 4'd7) begin
              rx_tcnt <= '0;
              if (!rx_sync) begin
                rx_state <= RX_DATA;
                rx_bcnt  <= '0;
                rx_perr  <= 1'b0;
              end else begin
                rx_state <= RX_IDLE;
              end
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_tcnt == 4'd15) begin
              rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
              rx_bcnt  <= rx_bcnt + 1'b1;
              if (rx_bcnt == LAST_BIT) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_tcnt == 4'd15) begin
              rx_perr  <= ((^rx_shift) ^ rx_sync) != ODD_PAR;
              rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_tcnt == 4'd15) begin
              rx_push     <= 1'b1;
              rx_push_dat <= {!rx_sync, rx_perr, rx_shift};
              rx_state    <= RX_IDLE;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [DATA_W+1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk      (sysclk),
    .rst_n    (reset),
    .push     (rx_push),
    .push_dat (rx_push_dat),
    .pop      (RX_READ),
    .pop_dat  (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (RX_COUNT)
  );

  assign UART_RXD = rx_head[DATA_W-1:0];
  assign RX_PERR  = rx_head[DATA_W];
  assign RX_FERR  = rx_head[DATA_W+1];
  assign RX_EFF   = !rx_empty;

  // Sticky overrun: set on a dropped byte, cleared by the first effective read
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                              RX_OVR <= 1'b0;
    else if (rx_push && rx_full && !RX_READ) RX_OVR <= 1'b1;
    else if (RX_READ && !rx_empty)           RX_OVR <= 1'b0;
  end

  // ---------------- TX path ----------------
  logic [DATA_W-1:0]         tx_head;
  logic                      tx_full;
  logic                      tx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                      tx_pop;
  logic                      tx_frame_end;

  tx_state_t         tx_state;
  logic [3:0]        tx_tcnt;
  logic [BCW-1:0]    tx_bcnt;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par;
  logic              tx_stop_idx;
  logic              tx_line;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (sysclk),
    .rst_n    (reset),
    .push     (TX_EN),
    .push_dat (UART_TXD),
    .pop      (tx_pop),
    .pop_dat  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  assign tx_frame_end = tick && (tx_state == TX_STOP) && (tx_tcnt == 4'd15) &&
                        (tx_stop_idx == STOP_LAST);
  // Next frame is fetched on a tick, either from idle or straight out of the last stop bit
  assign tx_pop = !tx_empty && ((tx_state == TX_IDLE && tick) || tx_frame_end);

  // Transmit FSM with registered line output; each bit spans 16 ticks
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_state    <= TX_IDLE;
      tx_tcnt     <= '0;
      tx_bcnt     <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_stop_idx <= 1'b0;
      tx_line     <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_tcnt  <= '0;
      tx_shift <= tx_head;
      tx_par   <= ODD_PAR ? ~^tx_head : ^tx_head;
      tx_line  <= 1'b0;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: tx_line <= 1'b1;
        TX_START: begin
          tx_tcnt <= tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            tx_state <= TX_DATA;
            tx_bcnt  <= '0;
            tx_line  <= tx_shift[0];
          end
        end
        TX_DATA: begin
          tx_tcnt <= tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bcnt == LAST_BIT) begin
              tx_stop_idx <= 1'b0;
              if (HAS_PAR) begin
                tx_state <= TX_PARITY;
                tx_line  <= tx_par;
              end else begin
                tx_state <= TX_STOP;
                tx_line  <= 1'b1;
              end
            end else begin
              tx_bcnt  <= tx_bcnt + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end
        end
        TX_PARITY: begin
          tx_tcnt <= tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            tx_state    <= TX_STOP;
            tx_stop_idx <= 1'b0;
            tx_line     <= 1'b1;
          end
        end
        TX_STOP: begin
          tx_tcnt <= tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            if (tx_stop_idx == STOP_LAST) tx_state    <= TX_IDLE;
            else                          tx_stop_idx <= 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  assign UART_TX   = tx_line;
  assign TX_STATUS = !tx_full;
  assign TX_BUSY   = (tx_state != TX_IDLE) || (tx_count != '0);

endmodule

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
module tb_uart_fifo;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;

  logic sysclk;
  logic reset;

  // dut0: no parity, used for TX scenarios
  logic          rx0_line;
  logic          tx0;
  logic [DW-1:0] rxd0;
  logic          perr0, ferr0, eff0, ovr0, status0, busy0;
  logic [2:0]    count0;
  logic          read0;
  logic [DW-1:0] txd0;
  logic          txen0;

  // dut2: even parity, used for RX scenarios
  logic          rx2_line;
  logic          tx2;
  logic [DW-1:0] rxd2;
  logic          perr2, ferr2, eff2, ovr2, status2, busy2;
  logic [2:0]    count2;
  logic          read2;
  logic [DW-1:0] txd2;
  logic          txen2;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];

  uart_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(DW), .PARITY(0), .STOP_BITS(1),
              .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut0 (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx0_line), .UART_TX(tx0),
    .UART_RXD(rxd0), .RX_PERR(perr0), .RX_FERR(ferr0), .RX_EFF(eff0),
    .RX_READ(read0), .RX_OVR(ovr0), .RX_COUNT(count0), .UART_TXD(txd0),
    .TX_EN(txen0), .TX_STATUS(status0), .TX_BUSY(busy0));

  uart_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(DW), .PARITY(2), .STOP_BITS(1),
              .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut2 (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx2_line), .UART_TX(tx2),
    .UART_RXD(rxd2), .RX_PERR(perr2), .RX_FERR(ferr2), .RX_EFF(eff2),
    .RX_READ(read2), .RX_OVR(ovr2), .RX_COUNT(count2), .UART_TXD(txd2),
    .TX_EN(txen2), .TX_STATUS(status2), .TX_BUSY(busy2));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one even-parity frame on dut2's RX line (caller is at a negedge)
  task automatic send_frame(input logic [DW-1:0] d, input logic par_bit,
                            input logic stop_bit, input bit store);
    logic [10:0] bits;
    bits = {stop_bit, par_bit, d, 1'b0};
    if (store) rx_q.push_back({~stop_bit, (^d) ^ par_bit, d});
    for (int i = 0; i < 11; i++) begin
      rx2_line = bits[i];
      repeat (16) @(negedge sysclk);
    end
    rx2_line = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  // Compare dut2's FIFO head against the scoreboard, then pop it
  task automatic check_rx_pop(input string name);
    logic [DW+1:0] exp;
    int n;
    n = 0;
    while (eff2 !== 1'b1 && n < 64) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (rx_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, eff=%b head=%h", name, eff2, rxd2);
    end else begin
      exp = rx_q.pop_front();
      if ({eff2, ferr2, perr2, rxd2} !== {1'b1, exp})
        begin
          errors++;
          $display("FAIL %s: got eff=%b ferr=%b perr=%b data=%h, want eff=1 ferr=%b perr=%b data=%h",
                   name, eff2, ferr2, perr2, rxd2, exp[DW+1], exp[DW], exp[DW-1:0]);
        end
    end
    read2 = 1'b1;
    @(negedge sysclk);
    read2 = 1'b0;
  endtask

  // Check a whole 10-bit frame on dut0's TX line, cycle by cycle (caller is at a negedge)
  task automatic capture_tx(input logic [DW-1:0] exp, input string name);
    logic [9:0] bits;
    int n, bad;
    bits = {1'b1, exp, 1'b0};
    n = 0;
    while (tx0 !== 1'b0 && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    if (tx0 !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: no start bit seen, line=%b want 0", name, tx0);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        if (tx0 !== bits[i]) bad++;
        @(negedge sysclk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: %0d of 16 cycles wrong, want level %b", name, i, bad, bits[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx0_line = 1'b1; rx2_line = 1'b1;
    read0 = 1'b0; read2 = 1'b0;
    txd0 = '0; txd2 = '0; txen0 = 1'b0; txen2 = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++;
    if ({tx0, eff0, ovr0, count0, status0, busy0, rxd0, perr0, ferr0} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut0: tx=%b eff=%b ovr=%b cnt=%0d st=%b busy=%b rxd=%h pe=%b fe=%b, want 1 0 0 0 1 0 00 0 0",
               tx0, eff0, ovr0, count0, status0, busy0, rxd0, perr0, ferr0);
    end
    checks++;
    if ({tx2, eff2, ovr2, count2, status2, busy2, rxd2, perr2, ferr2} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut2: tx=%b eff=%b ovr=%b cnt=%0d st=%b busy=%b rxd=%h pe=%b fe=%b, want 1 0 0 0 1 0 00 0 0",
               tx2, eff2, ovr2, count2, status2, busy2, rxd2, perr2, ferr2);
    end
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic test_tx();
    txd0 = 8'hA5; txen0 = 1'b1;
    @(negedge sysclk);
    txen0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL tx_busy_rise: got %b want 1", busy0);
    end
    capture_tx(8'hA5, "tx_a5");
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL tx_busy_fall: got %b want 0", busy0);
    end
  endtask

  task automatic test_rx_parity();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    check_rx_pop("rx_good");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_rx_pop("rx_perr");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check_rx_pop("rx_ferr");
    send_frame(8'hC7, 1'b1, 1'b1, 1'b1);
    check_rx_pop("rx_c7");
  endtask

  task automatic test_glitch();
    rx2_line = 1'b0;
    repeat (4) @(negedge sysclk);
    rx2_line = 1'b1;
    repeat (40) @(negedge sysclk);
    checks++;
    if (eff2 !== 1'b0 || count2 !== 3'd0) begin
      errors++;
      $display("FAIL glitch: eff=%b count=%0d want eff=0 count=0", eff2, count2);
    end
  endtask

  task automatic test_overrun();
    int  model_cnt;
    bit  model_ovr;
    logic [DW-1:0] d;
    model_cnt = 0;
    model_ovr = 0;
    for (int i = 1; i <= 5; i++) begin
      d = DW'(i);
      send_frame(d, ^d, 1'b1, model_cnt < DEPTH);
      if (model_cnt < DEPTH) model_cnt++;
      else model_ovr = 1;
    end
    repeat (4) @(negedge sysclk);
    checks++;
    if (count2 !== 3'(model_cnt) || ovr2 !== model_ovr) begin
      errors++;
      $display("FAIL overrun_state: count=%0d ovr=%b want count=%0d ovr=%b", count2, ovr2, model_cnt, model_ovr);
    end
    check_rx_pop("ovr_rd1");
    checks++;
    if (ovr2 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%b want 0", ovr2);
    end
    check_rx_pop("ovr_rd2");
    check_rx_pop("ovr_rd3");
    check_rx_pop("ovr_rd4");
    checks++;
    if (eff2 !== 1'b0 || count2 !== 3'd0) begin
      errors++;
      $display("FAIL overrun_drain: eff=%b count=%0d want 0 0", eff2, count2);
    end
  endtask

  task automatic test_tx_full();
    fork
      begin
        int accepted;
        bit exp_st;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
          txd0 = 8'h10 + 8'(i);
          txen0 = 1'b1;
          // one entry leaves for the shifter right after the first push
          exp_st = (accepted < DEPTH + 1);
          checks++;
          if (status0 !== exp_st) begin
            errors++;
            $display("FAIL tx_status%0d: got %b want %b", i, status0, exp_st);
          end
          if (exp_st) begin
            tx_q.push_back(txd0);
            accepted++;
          end
          @(negedge sysclk);
        end
        txen0 = 1'b0;
      end
      begin
        repeat (DEPTH + 1) begin
          logic [DW-1:0] e;
          wait (tx_q.size() != 0);
          e = tx_q.pop_front();
          capture_tx(e, "tx_full_frame");
        end
      end
    join
    repeat (200) begin
      if (tx0 !== 1'b1) break;
      @(negedge sysclk);
    end
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL tx_drop6: line=%b busy=%b want line=1 busy=0", tx0, busy0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    txd0 = 8'h00; txen0 = 1'b1;
    @(negedge sysclk);
    txen0 = 1'b0;
    n = 0;
    while (tx0 !== 1'b0 && n < 100) begin
      @(negedge sysclk);
      n++;
    end
    repeat (40) @(negedge sysclk);
    checks++;
    if (tx0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_level: line=%b want 0", tx0);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: line=%b busy=%b want 1 0", tx0, busy0);
    end
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    txd0 = 8'h5A; txen0 = 1'b1;
    @(negedge sysclk);
    txen0 = 1'b0;
    capture_tx(8'h5A, "tx_after_reset");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_parity();
    test_glitch();
    test_overrun();
    test_tx_full();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
